// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock by
//   time-sharing an external combinational 4-bit adder (add4).  The result is
//   assembled in a register and held until the next accepted start.
//
//   Build option: define SIGNED_OVF_EN to add the registered signed-overflow
//   output 'ovf'.  Without it the port and its logic are absent.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin an addition (only honoured in IDLE)
//   op_a/op_b in   W-bit operands, captured on accepted start
//   cin       in   carry-in, captured on accepted start
//   busy      out  high in RUN and DONE
//   done      out  one-cycle pulse, sum/cout valid
//   sum       out  W-bit registered result
//   cout      out  registered final carry
//   ovf       out  signed overflow (SIGNED_OVF_EN only)
//   add_A/B   out  nibble operands to the external adder (0 outside RUN)
//   add_Cin   out  carry to the external adder (0 outside RUN)
//   add_Sum   in   external adder sum, combinational
//   add_Cout  in   external adder carry-out, combinational
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
`ifdef SIGNED_OVF_EN
  output logic                   ovf,
`endif
  output logic [3:0]             add_A,
  output logic [3:0]             add_B,
  output logic                   add_Cin,
  input  logic [3:0]             add_Sum,
  input  logic                   add_Cout
);

  localparam int W = 4 * NIBBLES;
  localparam logic [3:0] LAST_CNT = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [W-1:0]   a_sh_r;
  logic [W-1:0]   b_sh_r;
  logic [3:0]     cnt_r;
  logic [W-1:0]   sum_r;
  logic           cout_r;
  logic           busy_r;
  logic           done_r;
  logic [3:0]     add_a_r;
  logic [3:0]     add_b_r;
  // Carry register; it also drives add_Cin directly so that output stays
  // registered.  It is cleared on the final edge once its value is in cout_r.
  logic           carry_r;
`ifdef SIGNED_OVF_EN
  logic           a_msb_r;
  logic           b_msb_r;
  logic           ovf_r;
`endif

  logic [W-1:0]   a_next_s;
  logic [W-1:0]   b_next_s;
  logic [W-1:0]   sum_next_s;
  logic           last_s;

  // Next-state helpers: operand shift, nibble merge into sum, last-nibble flag.
  always_comb begin
    a_next_s   = a_sh_r >> 3'd4;
    b_next_s   = b_sh_r >> 3'd4;
    last_s     = (cnt_r == LAST_CNT);
    sum_next_s = sum_r;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_r == 4'(i)) begin
        sum_next_s[i*4 +: 4] = add_Sum;
      end else begin
        sum_next_s[i*4 +: 4] = sum_r[i*4 +: 4];
      end
    end
  end

  // Control FSM plus datapath registers; all outputs come from these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      cnt_r   <= 4'd0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      add_a_r <= 4'd0;
      add_b_r <= 4'd0;
      carry_r <= 1'b0;
`ifdef SIGNED_OVF_EN
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            a_sh_r  <= op_a;
            b_sh_r  <= op_b;
            carry_r <= cin;
            cnt_r   <= 4'd0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            // Pre-load the adder inputs so the first RUN cycle sees nibble 0.
            add_a_r <= op_a[3:0];
            add_b_r <= op_b[3:0];
`ifdef SIGNED_OVF_EN
            a_msb_r <= op_a[W-1];
            b_msb_r <= op_b[W-1];
            ovf_r   <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_r  <= sum_next_s;
          a_sh_r <= a_next_s;
          b_sh_r <= b_next_s;
          cnt_r  <= cnt_r + 4'd1;
          if (last_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            cout_r  <= add_Cout;
            add_a_r <= 4'd0;
            add_b_r <= 4'd0;
            carry_r <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_r   <= (a_msb_r == b_msb_r) && (add_Sum[3] != a_msb_r);
`endif
          end else begin
            state_r <= ST_RUN;
            add_a_r <= a_next_s[3:0];
            add_b_r <= b_next_s[3:0];
            carry_r <= add_Cout;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          add_a_r <= 4'd0;
          add_b_r <= 4'd0;
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign sum     = sum_r;
  assign cout    = cout_r;
  assign add_A   = add_a_r;
  assign add_B   = add_b_r;
  assign add_Cin = carry_r;
`ifdef SIGNED_OVF_EN
  assign ovf     = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  // NIBBLES=4 instance
  logic        start;
  logic [15:0] op_a, op_b;
  logic        cin;
  logic        busy, done, cout;
  logic [15:0] sum;
  logic [3:0]  add_A, add_B, add_Sum;
  logic        add_Cin, add_Cout;
`ifdef SIGNED_OVF_EN
  logic        ovf;
  logic        ovf1;
`endif

  // NIBBLES=1 instance
  logic        start1;
  logic [3:0]  op_a1, op_b1;
  logic        cin1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;
  logic [3:0]  add_A1, add_B1, add_Sum1;
  logic        add_Cin1, add_Cout1;

  int errors;
  int checks;

  // External add4 models
  assign {add_Cout,  add_Sum}  = {1'b0, add_A}  + {1'b0, add_B}  + {4'd0, add_Cin};
  assign {add_Cout1, add_Sum1} = {1'b0, add_A1} + {1'b0, add_B1} + {4'd0, add_Cin1};

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
`ifdef SIGNED_OVF_EN
    .ovf(ovf),
`endif
    .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
    .add_Sum(add_Sum), .add_Cout(add_Cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
`ifdef SIGNED_OVF_EN
    .ovf(ovf1),
`endif
    .add_A(add_A1), .add_B(add_B1), .add_Cin(add_Cin1),
    .add_Sum(add_Sum1), .add_Cout(add_Cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one addition on the 4-nibble DUT and stop at the negedge where done
  // is seen.  lat counts RUN cycles before done (-1 on timeout); cin_tr holds
  // add_Cin seen in RUN cycles 1..4.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output int lat, output logic [3:0] cin_tr);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    cin_tr = 4'd0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (k < 4) cin_tr[k] = add_Cin;
      @(negedge clk);
    end
  endtask

  int         lat;
  logic [3:0] ctr;
  int         pulses;
  logic [15:0] seen_sum;

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; op_a = 16'd0; op_b = 16'd0; cin = 1'b0;
    start1 = 1'b0; op_a1 = 4'd0; op_b1 = 4'd0; cin1 = 1'b0;

    #3;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_sum", {16'd0, sum}, 32'd0);
    check_eq("rst_addA", {28'd0, add_A}, 32'd0);
    check_eq("rst_addCin", {31'd0, add_Cin}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 0x1234 + 0x4321 + 1
    do_add(16'h1234, 16'h4321, 1'b1, lat, ctr);
    check_eq("t1_latency", lat, 32'd4);
    check_eq("t1_sum", {16'd0, sum}, 32'h5556);
    check_eq("t1_cout", {31'd0, cout}, 32'd0);
    check_eq("t1_busy_done", {31'd0, busy}, 32'd1);
    check_eq("t1_addA_done", {28'd0, add_A}, 32'd0);
    check_eq("t1_cin_trace", {28'd0, ctr}, 32'h1);
    @(negedge clk);
    check_eq("t1_done_pulse", {31'd0, done}, 32'd0);
    check_eq("t1_busy_idle", {31'd0, busy}, 32'd0);
    check_eq("t1_sum_hold", {16'd0, sum}, 32'h5556);

    // 0xFFFF + 0x0001: carry ripples through every nibble
    do_add(16'hFFFF, 16'h0001, 1'b0, lat, ctr);
    check_eq("t2_latency", lat, 32'd4);
    check_eq("t2_sum", {16'd0, sum}, 32'h0000);
    check_eq("t2_cout", {31'd0, cout}, 32'd1);
    check_eq("t2_cin_trace", {28'd0, ctr}, 32'hE);

    // start during RUN is ignored
    @(negedge clk);
    op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;                  // RUN1
    @(negedge clk); op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1; // RUN2
    @(negedge clk); start = 1'b0;                  // RUN3
    pulses = 0; seen_sum = 16'hDEAD;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        pulses++;
        seen_sum = sum;
      end
      @(negedge clk);
    end
    check_eq("t3_done_pulses", pulses, 32'd1);
    check_eq("t3_sum", {16'd0, seen_sum}, 32'h0002);
    check_eq("t3_cout", {31'd0, cout}, 32'd0);

    // start held high: one IDLE cycle between operations, late operand change ignored
    op_a = 16'h0011; op_b = 16'h0022; cin = 1'b0; start = 1'b1;
    @(negedge clk);                                // RUN1
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check_eq("t4_latency", lat, 32'd4);
    check_eq("t4_sum_first", {16'd0, sum}, 32'h0033);
    @(negedge clk);
    check_eq("t4_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("t4_restart", {31'd0, busy}, 32'd1);
    start = 1'b0; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check_eq("t4_latency2", lat, 32'd4);
    check_eq("t4_sum_second", {16'd0, sum}, 32'h0033);
    check_eq("t4_cout_second", {31'd0, cout}, 32'd0);

    // asynchronous reset in the 2nd RUN cycle
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;                  // RUN1
    @(negedge clk);                                // RUN2
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_done", {31'd0, done}, 32'd0);
    check_eq("t5_sum", {16'd0, sum}, 32'd0);
    check_eq("t5_cout", {31'd0, cout}, 32'd0);
    check_eq("t5_addA", {28'd0, add_A}, 32'd0);
    check_eq("t5_addB", {28'd0, add_B}, 32'd0);
    check_eq("t5_addCin", {31'd0, add_Cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check_eq("t5_no_done", pulses, 32'd0);
    do_add(16'h00FF, 16'h0001, 1'b0, lat, ctr);
    check_eq("t5_latency", lat, 32'd4);
    check_eq("t5_sum_after", {16'd0, sum}, 32'h0100);
    check_eq("t5_cout_after", {31'd0, cout}, 32'd0);

`ifdef SIGNED_OVF_EN
    do_add(16'h7FFF, 16'h0001, 1'b0, lat, ctr);
    check_eq("t6_ovf_set", {31'd0, ovf}, 32'd1);
    check_eq("t6_sum", {16'd0, sum}, 32'h8000);
    do_add(16'hFFFF, 16'h0001, 1'b0, lat, ctr);
    check_eq("t6_ovf_clear", {31'd0, ovf}, 32'd0);
    check_eq("t6_cout", {31'd0, cout}, 32'd1);
`endif

    // exhaustive sweep of the single-nibble instance
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          op_a1 = 4'(a); op_b1 = 4'(b); cin1 = 1'(c); start1 = 1'b1;
          @(negedge clk); start1 = 1'b0;           // RUN
          @(negedge clk);                          // DONE
          check_eq("sweep_done", {31'd0, done1}, 32'd1);
          check_eq("sweep_sum", {27'd0, cout1, sum1}, 32'(a + b + c));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
